micro_sequencer: RTL and testbench

- Control-address register (CAR) plus control-register (CR) sequencer for the microprogrammed control unit.
- Presents CAR to the external synchronous control-store ROM and captures the returned control word into CR.
- Drives the next-address field and branch bit to the next-address logic, then loads that logic's decision back into CAR.
- One microinstruction takes two clocks (FETCH, EXEC), with stall and halt support.

---
 rtl/micro_pkg.sv | 44 ++++
 rtl/micro_sequencer_sat_counter.sv | 19 +
 rtl/micro_sequencer.sv | 99 +++++++++
 tb/tb_micro_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/micro_pkg.sv
// Shared definitions for the microprogrammed control unit: sequencer states,
// default widths and control-word field positions.
package micro_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned CW_W_DEF   = 24;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam logic [ADDR_W_DEF-1:0] START_ADDR_DEF = 5'b00000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    // Control word layout, top down: naddr | br | end | ctrl
    function automatic int unsigned naddr_msb(input int unsigned cw_w);
        return cw_w - 1;
    endfunction

    function automatic int unsigned naddr_lsb(input int unsigned cw_w, input int unsigned addr_w);
        return cw_w - addr_w;
    endfunction

    function automatic int unsigned br_bit(input int unsigned cw_w, input int unsigned addr_w);
        return cw_w - addr_w - 1;
    endfunction

    function automatic int unsigned end_bit(input int unsigned cw_w, input int unsigned addr_w);
        return cw_w - addr_w - 2;
    endfunction

    function automatic int unsigned ctrl_msb(input int unsigned cw_w, input int unsigned addr_w);
        return cw_w - addr_w - 3;
    endfunction

    localparam int unsigned NADDR_MSB = naddr_msb(CW_W_DEF);
    localparam int unsigned NADDR_LSB = naddr_lsb(CW_W_DEF, ADDR_W_DEF);
    localparam int unsigned BR_BIT    = br_bit(CW_W_DEF, ADDR_W_DEF);
    localparam int unsigned END_BIT   = end_bit(CW_W_DEF, ADDR_W_DEF);
    localparam int unsigned CTRL_MSB  = ctrl_msb(CW_W_DEF, ADDR_W_DEF);

endpackage

// File: rtl/micro_sequencer_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// CAR/CR sequencer: addresses the control store, holds the current control
// word and steps FETCH -> EXEC per microinstruction, with stall and halt.
module micro_sequencer
    import micro_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CW_W   = CW_W_DEF,
    parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(START_ADDR_DEF),
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   stall,
    input  logic [ADDR_W-1:0]      next_addr_in,
    output logic [ADDR_W-1:0]      cs_addr,
    input  logic [CW_W-1:0]        cs_data,
    output logic [ADDR_W-1:0]      naddr_out,
    output logic                   br_out,
    output logic [CW_W-ADDR_W-3:0] ctrl_out,
    output logic                   ctrl_valid,
    output logic                   running,
    output logic                   halted,
    output logic [CNT_W-1:0]       retired
);

    localparam int unsigned CR_NADDR_MSB = naddr_msb(CW_W);
    localparam int unsigned CR_NADDR_LSB = naddr_lsb(CW_W, ADDR_W);
    localparam int unsigned CR_BR        = br_bit(CW_W, ADDR_W);
    localparam int unsigned CR_END       = end_bit(CW_W, ADDR_W);
    localparam int unsigned CR_CTRL_MSB  = ctrl_msb(CW_W, ADDR_W);

    state_e              state;
    logic [ADDR_W-1:0]   car;
    logic [CW_W-1:0]     cr;
    logic                retire_en;

    // Sequencer state, CAR, CR and the registered status flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            car     <= START_ADDR;
            cr      <= '0;
            running <= 1'b0;
            halted  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state   <= ST_FETCH;
                        car     <= START_ADDR;
                        running <= 1'b1;
                        halted  <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    cr    <= cs_data;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (!stall) begin
                        if (cr[CR_END]) begin
                            state   <= ST_HALT;
                            running <= 1'b0;
                            halted  <= 1'b1;
                        end else begin
                            car   <= next_addr_in;
                            state <= ST_FETCH;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

    // A microinstruction retires on the unstalled EXEC cycle
    assign retire_en  = (state == ST_EXEC) && !stall;
    assign ctrl_valid = retire_en;

    assign cs_addr   = car;
    assign naddr_out = cr[CR_NADDR_MSB:CR_NADDR_LSB];
    assign br_out    = cr[CR_BR];
    assign ctrl_out  = cr[CR_CTRL_MSB:0];

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_retired (
        .clk   (clk),
        .rstn  (rstn),
        .en    (retire_en),
        .count (retired)
    );

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed program plus a randomized
// program checked against an instruction-level model.
module tb_micro_sequencer;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 24;
    localparam int unsigned KW = CW - AW - 2;

    logic          clk;
    logic          rstn;
    logic          start;
    logic          stall;
    logic [AW-1:0] next_addr_in;
    logic [AW-1:0] cs_addr;
    logic [CW-1:0] cs_data;
    logic [AW-1:0] naddr_out;
    logic          br_out;
    logic [KW-1:0] ctrl_out;
    logic          ctrl_valid;
    logic          running;
    logic          halted;
    logic [15:0]   retired;

    logic          start_s;
    logic [AW-1:0] cs_addr_s;
    logic [CW-1:0] cs_data_s;
    logic [AW-1:0] naddr_out_s;
    logic          br_out_s;
    logic [KW-1:0] ctrl_out_s;
    logic          ctrl_valid_s;
    logic          running_s;
    logic          halted_s;
    logic [3:0]    retired_s;

    logic [CW-1:0] rom [32];

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] m_pc;
    logic [15:0]   m_ret;

    // Control store: its address register is the CAR, so data follows cs_addr
    assign cs_data   = rom[cs_addr];
    assign cs_data_s = {AW'(cs_addr_s + AW'(1)), 1'b0, 1'b0, KW'(0)};

    micro_sequencer dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .stall        (stall),
        .next_addr_in (next_addr_in),
        .cs_addr      (cs_addr),
        .cs_data      (cs_data),
        .naddr_out    (naddr_out),
        .br_out       (br_out),
        .ctrl_out     (ctrl_out),
        .ctrl_valid   (ctrl_valid),
        .running      (running),
        .halted       (halted),
        .retired      (retired)
    );

    micro_sequencer #(.CNT_W(4)) u_sat (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start_s),
        .stall        (1'b0),
        .next_addr_in (naddr_out_s),
        .cs_addr      (cs_addr_s),
        .cs_data      (cs_data_s),
        .naddr_out    (naddr_out_s),
        .br_out       (br_out_s),
        .ctrl_out     (ctrl_out_s),
        .ctrl_valid   (ctrl_valid_s),
        .running      (running_s),
        .halted       (halted_s),
        .retired      (retired_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [CW-1:0] mk(input logic [AW-1:0] na, input logic br,
                                         input logic en, input logic [KW-1:0] c);
        return {na, br, en, c};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE or HALT; returns at the negedge of FETCH
    task automatic do_start();
        start = 1'b1;
        stall = 1'b0;
        #1;
        chk("pre_start_running", 32'(running), 32'd0);
        @(negedge clk);
        start = 1'b0;
        m_pc  = 5'd0;
    endtask

    // One microinstruction from its FETCH negedge; returns at the next FETCH/HALT negedge
    task automatic run_instr(input logic [AW-1:0] nxt, input int stalls, input bit start_mid);
        logic [CW-1:0] w;
        w = rom[m_pc];
        stall        = 1'($urandom);
        next_addr_in = AW'($urandom);
        start        = 1'b0;
        #1;
        chk("fetch_addr",    32'(cs_addr),    32'(m_pc));
        chk("fetch_valid",   32'(ctrl_valid), 32'd0);
        chk("fetch_running", 32'(running),    32'd1);
        @(negedge clk);
        for (int s = 0; s < stalls; s++) begin
            stall        = 1'b1;
            next_addr_in = AW'($urandom);
            #1;
            chk("stall_valid", 32'(ctrl_valid), 32'd0);
            chk("stall_addr",  32'(cs_addr),    32'(m_pc));
            chk("stall_ret",   32'(retired),    32'(m_ret));
            chk("stall_ctrl",  32'(ctrl_out),   32'(w[KW-1:0]));
            @(negedge clk);
        end
        stall        = 1'b0;
        next_addr_in = nxt;
        start        = start_mid;
        #1;
        chk("exec_valid", 32'(ctrl_valid), 32'd1);
        chk("exec_naddr", 32'(naddr_out),  32'(w[CW-1 -: AW]));
        chk("exec_br",    32'(br_out),     32'(w[CW-AW-1]));
        chk("exec_ctrl",  32'(ctrl_out),   32'(w[KW-1:0]));
        chk("exec_ret",   32'(retired),    32'(m_ret));
        chk("exec_addr",  32'(cs_addr),    32'(m_pc));
        if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
        if (!w[CW-AW-2]) m_pc = nxt;
        @(negedge clk);
        start = 1'b0;
        if (w[CW-AW-2]) begin
            #1;
            chk("halt_flag",    32'(halted),     32'd1);
            chk("halt_running", 32'(running),    32'd0);
            chk("halt_valid",   32'(ctrl_valid), 32'd0);
            chk("halt_ret",     32'(retired),    32'(m_ret));
            chk("halt_addr",    32'(cs_addr),    32'(m_pc));
        end
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; stall = 1'b0; next_addr_in = '0; start_s = 1'b0;
        m_pc = '0; m_ret = '0;
        for (int i = 0; i < 32; i++) rom[i] = '0;

        // Reset values
        #3;
        chk("rst_addr",    32'(cs_addr),    32'd0);
        chk("rst_valid",   32'(ctrl_valid), 32'd0);
        chk("rst_running", 32'(running),    32'd0);
        chk("rst_halted",  32'(halted),     32'd0);
        chk("rst_retired", 32'(retired),    32'd0);
        chk("rst_ctrl",    32'(ctrl_out),   32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed program: linear, stalled, branch, end
        rom[0]  = mk(5'd1,  1'b0, 1'b0, 17'h0A5A5);
        rom[1]  = mk(5'd2,  1'b0, 1'b0, 17'h11111);
        rom[2]  = mk(5'd3,  1'b0, 1'b0, 17'h02222);
        rom[3]  = mk(5'd4,  1'b1, 1'b0, 17'h13333);
        rom[11] = mk(5'd31, 1'b0, 1'b0, 17'h04444);
        rom[31] = mk(5'd7,  1'b1, 1'b0, 17'h1FFFF);
        rom[7]  = mk(5'd9,  1'b0, 1'b1, 17'h05555);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stall = 1'($urandom);
            #1;
            chk("idle_running", 32'(running), 32'd0);
            chk("idle_valid",   32'(ctrl_valid), 32'd0);
        end
        stall = 1'b0;

        do_start();
        run_instr(5'd1,  0, 1'b0);
        run_instr(5'd2,  0, 1'b1);
        run_instr(5'd3,  3, 1'b0);
        run_instr(5'd11, 0, 1'b0);
        run_instr(5'd31, 1, 1'b1);
        run_instr(5'd7,  0, 1'b0);
        run_instr(5'd20, 2, 1'b0);

        repeat (2) begin
            @(negedge clk);
            #1;
            chk("halt_hold", 32'(halted), 32'd1);
            chk("halt_hold_ret", 32'(retired), 32'(m_ret));
        end

        do_start();
        run_instr(5'd1, 0, 1'b0);
        run_instr(5'd2, 0, 1'b0);

        // Reset in the middle of EXEC
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst_addr",    32'(cs_addr),    32'd0);
        chk("midrst_valid",   32'(ctrl_valid), 32'd0);
        chk("midrst_retired", 32'(retired),    32'd0);
        chk("midrst_running", 32'(running),    32'd0);
        chk("midrst_naddr",   32'(naddr_out),  32'd0);
        m_ret = '0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("post_rst_idle", 32'(running), 32'd0);
        end

        // Randomized program
        for (int i = 0; i < 32; i++) begin
            rom[i] = CW'($urandom);
            rom[i][CW-AW-2] = 1'b0;
        end
        do_start();
        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] nx;
            nx = ($urandom_range(0, 3) == 0) ? 5'd31 : AW'($urandom);
            run_instr(nx, $urandom_range(0, 3), 1'($urandom));
        end
        rom[m_pc][CW-AW-2] = 1'b1;
        run_instr(AW'($urandom), $urandom_range(0, 2), 1'b0);

        // Saturating retired counter on the 4-bit instance
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("sat_mid", 32'(retired_s), 32'd5);
        repeat (40) @(negedge clk);
        #1;
        chk("sat_top", 32'(retired_s), 32'd15);
        chk("sat_running", 32'(running_s), 32'd1);
        repeat (5) @(negedge clk);
        #1;
        chk("sat_hold", 32'(retired_s), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
